// File: rtl/n_bit_sipo_deser.sv
// Serial-in/parallel-out deserializer with a valid/ready output register and sticky overrun flag.
// Define PARITY_CHK_EN to expect a trailing parity bit per word and report mismatches on o_parity_err.
module n_bit_sipo_deser #(
   parameter int WIDTH      = 8,
   parameter int LSB_FIRST  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_serial,
   input  logic             i_bit_valid,
   input  logic             i_sync,
   output logic [WIDTH-1:0] o_parallel,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_busy,
   output logic             o_overrun,
   input  logic             i_clr_err,
   output logic             o_parity_err
);

   localparam int CW = $clog2(WIDTH + 2);
`ifdef PARITY_CHK_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   if (WIDTH < 2 || LSB_FIRST > 1 || PARITY_ODD > 1) begin : g_param_check
      $error("n_bit_sipo_deser: WIDTH must be >= 2, LSB_FIRST and PARITY_ODD must be 0 or 1");
   end

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             word_done;
   logic             out_free;
   logic             shift_en;
   logic             perr_nxt;

   // A sync with a qualified bit starts a new word with that bit as bit 0.
   always_comb begin
      cnt_nxt = cnt;
      if (i_sync) begin
         cnt_nxt = i_bit_valid ? CW'(1) : '0;
      end else if (i_bit_valid) begin
         cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign word_done = i_bit_valid && !i_sync && (cnt == CNT_LAST);
   assign out_free  = !o_valid || i_ready;

`ifdef PARITY_CHK_EN
   logic par_acc;
   logic par_acc_nxt;
   logic par_slot;

   // The final slot carries parity and never enters the shift register.
   assign par_slot = (cnt == CNT_LAST) && !i_sync;
   assign shift_en = i_bit_valid && !par_slot;
   assign perr_nxt = i_serial != (par_acc ^ (PARITY_ODD != 0));

   always_comb begin
      par_acc_nxt = par_acc;
      if (i_sync) begin
         par_acc_nxt = i_bit_valid & i_serial;
      end else if (i_bit_valid) begin
         par_acc_nxt = par_slot ? 1'b0 : (par_acc ^ i_serial);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_acc <= 1'b0;
      end else begin
         par_acc <= par_acc_nxt;
      end
   end
`else
   assign shift_en = i_bit_valid;
   assign perr_nxt = 1'b0;
`endif

   if (LSB_FIRST != 0) begin : g_lsb_first
      always_comb begin
         sr_nxt = sr;
         if (shift_en) begin
            sr_nxt = {i_serial, sr[WIDTH-1:1]};
         end
      end
   end else begin : g_msb_first
      always_comb begin
         sr_nxt = sr;
         if (shift_en) begin
            sr_nxt = {sr[WIDTH-2:0], i_serial};
         end
      end
   end

   // sr_nxt already contains the final data bit, so a completed word loads on the sampling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr           <= '0;
         cnt          <= '0;
         o_busy       <= 1'b0;
         o_parallel   <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         sr     <= sr_nxt;
         cnt    <= cnt_nxt;
         o_busy <= (cnt_nxt != '0);

         if (word_done && out_free) begin
            o_parallel   <= sr_nxt;
            o_valid      <= 1'b1;
            o_parity_err <= perr_nxt;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end

         if (word_done && !out_free) begin
            o_overrun <= 1'b1;
         end else if (i_clr_err) begin
            o_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: doc/n_bit_sipo_deser.md
Name: n_bit_sipo_deser

Overview:
Serial-in/parallel-out deserializer. It is the receive-side counterpart of the team's n-bit PISO shift register. It collects qualified serial bits into a WIDTH-bit word and presents each completed word on a valid/ready output register. It sits at the receive end of the team's serial links, ahead of word-level consumers such as FIFOs and register files.

Parameters:
WIDTH, 8, number of data bits per word (min 2)
LSB_FIRST, 1, 1 = first received bit lands in o_parallel[0] (matches PISO shift-out order); 0 = first bit lands in o_parallel[WIDTH-1]
PARITY_ODD, 0, parity sense when PARITY_CHK_EN is defined (0 = even, 1 = odd); ignored otherwise

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
i_serial  input  1  serial data bit
i_bit_valid  input  1  qualifies i_serial this cycle; gaps allowed
i_sync  input  1  word-boundary marker, restarts bit count
o_parallel  output  WIDTH  last completed word
o_valid  output  1  o_parallel holds an unconsumed word
i_ready  input  1  consumer accepts word when o_valid && i_ready
o_busy  output  1  partial word in progress (bit count != 0)
o_overrun  output  1  sticky: a completed word was dropped
i_clr_err  input  1  synchronous clear of o_overrun
o_parity_err  output  1  parity mismatch for current word (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): shift register 0, bit counter 0, o_parallel 0, o_valid 0, o_busy 0, o_overrun 0, o_parity_err 0. Effective immediately, independent of clk; a partial word is discarded.
- Bit counter cnt has width $clog2(WIDTH+2) and counts 0..N-1. N = WIDTH, or WIDTH+1 when PARITY_CHK_EN is defined.
- Shifting only occurs when i_bit_valid=1.
  - LSB_FIRST=1: sr <= {i_serial, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], i_serial}.
  - The parity bit is not shifted into sr.
- i_sync=1 with i_bit_valid=1: the sampled bit is bit 0 of a new word. Any partial word is discarded and cnt becomes 1.
- i_sync=1 with i_bit_valid=0: cnt becomes 0 and the partial word is discarded. sr contents are don't-care.
- Word completion: a qualified bit sampled with cnt==N-1.
  - cnt returns to 0.
  - The assembled word, including the final bit, is available for load into o_parallel on the same edge.
  - Latency: o_valid=1 in the cycle after the edge that sampled the last bit.
- Output register:
  - Handshake occurs at any edge with o_valid && i_ready. o_valid clears unless a new word loads on the same edge.
  - Completion while output is free (o_valid=0, or handshake this edge): load o_parallel, set o_valid=1. Back-to-back words with i_ready held high give no loss.
  - Completion while o_valid=1 && i_ready=0: the new word is dropped, the old word is held, and o_overrun is set.
  - o_parallel and o_parity_err are stable while o_valid=1 and not handshaken.
  - o_parallel retains its last value after the handshake.
- o_overrun: sticky. Cleared by i_clr_err=1 or reset. If a set event and i_clr_err occur on the same edge, the set wins.
- o_busy = (cnt != 0), registered.
- i_ready is ignored while o_valid=0.
- With WIDTH=1 unsupported: elaboration error via generate check.

Optional Feature:
PARITY_CHK_EN
- Defined:
  - Each word is WIDTH data bits followed by one parity bit (N=WIDTH+1).
  - The running XOR of the data bits is accumulated and compared with the parity bit. Expected parity bit = XOR(data) ^ PARITY_ODD.
  - o_parity_err is loaded alongside o_parallel: 1 on mismatch.
  - A dropped (overrun) word does not affect o_parity_err.
- Not defined: N=WIDTH, no parity logic, o_parity_err tied 0.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, after reset send bits 1,0,1,0,0,1,0,1 with i_bit_valid=1 every cycle and i_ready=1 -> one cycle after the 8th bit edge, o_valid=1 and o_parallel=0xA5; o_valid=0 next cycle; o_overrun=0.
2. Same stimulus with LSB_FIRST=0 and random 0-3 cycle gaps in i_bit_valid -> o_parallel=0xA5 sent as 1,0,1,0,0,1,0,1 MSB-first; o_busy=1 from bit 1 through bit 7, 0 after completion.
3. Backpressure: i_ready=0, send 0x3C then 0xC3 -> o_parallel stays 0x3C, o_valid=1, o_overrun=1 after the second word; raise i_ready -> 0x3C consumed, o_valid=0; pulse i_clr_err -> o_overrun=0.
4. Sync recovery: send 3 bits, then assert i_sync with the first bit of 0x5A followed by its 7 remaining bits -> exactly one word out, o_parallel=0x5A.
5. Reset mid-word: send 5 bits, drop rst_n asynchronously between edges -> all outputs 0 immediately; after release, 0x81 received correctly.
6. PARITY_CHK_EN defined, PARITY_ODD=0: 0xA5 + parity 0 -> o_parity_err=0; 0xA5 + parity 1 -> o_parity_err=1, o_parallel=0xA5 in both cases.
